mux4_sel_arb: RTL and testbench
===============================

# mux4_sel_arb

Round-robin selection sequencer that sits directly upstream of the 4:1 bit multiplexer and drives its 2-bit `sel`. It arbitrates four request lines, holds a grant until the requester signals completion, drops the request, or exhausts a hold budget, then inserts one dead cycle before switching. The `sel` output connects straight to the mux select; `grant` and `busy` go to the requesters.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one grant may be held; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per mux input; bit i requests mux input i.
- `done`  in  1  current owner finished; sampled only in GRANT.
- `sel`  out  2  registered mux select; equals index of current/last grant.
- `grant`  out  4  registered one-hot grant; all-zero when no owner.
- `busy`  out  1  high exactly while `grant` is non-zero.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

## Operation
- States: IDLE, GRANT, RELEASE. Reset → IDLE.
- Reset values: `sel`=0, `grant`=0, `busy`=0, `timeout`=0, priority pointer `last`=3, hold counter=0.
- Pick rule (IDLE and RELEASE): search from `last`+1 upward, mod 4; first set `req` bit wins. No req → IDLE.
- IDLE/RELEASE with winner w → GRANT: `grant`=1<<w, `sel`=w, `busy`=1, counter=1.
- GRANT exit conditions, priority order: `done`=1; `req[sel]`=0; counter==HOLD_MAX. Any → RELEASE, `grant`=0, `busy`=0, `last`=`sel`; `timeout`=1 only if exiting solely by counter.
- GRANT otherwise: hold, counter+1 (saturating width $clog2(HOLD_MAX+1)).
- RELEASE: `grant`=0 for exactly one cycle; then applies pick rule directly (no return through IDLE when requests pending).
- `sel` keeps the last granted index in IDLE/RELEASE; never changes while `busy`=1.
- Requests from non-owners are ignored during GRANT.
- `rst` mid-grant: next edge forces all reset values; no `timeout` pulse.

## Timing
- `req` first high at edge N (IDLE) → `grant`/`sel` valid after edge N+1: 1-cycle latency.
- `done` high at edge M → `grant`=0 after M+1; next owner granted after M+2 (one guaranteed dead cycle).
- Max hold: `grant` high for exactly HOLD_MAX cycles; `timeout` high in the first RELEASE cycle.
- HOLD_MAX=1: every grant lasts one cycle, alternating grant/dead cycles.
- All outputs registered; no combinational input-to-output path.

## Structure
- Shared package `mux4_pkg`: state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2), `SEL_W`=2, `N_IN`=4.
- One sub-module: `rr_pick4` — combinational rotating priority pick (inputs `req`, `last`; outputs `found`, `idx[1:0]`).
- Top holds FSM, counter, pointer, output registers.

## Test plan
- Reset then `req`=4'b0001 → after 1 cycle `grant`=0001, `sel`=0, `busy`=1; `done` pulse → `grant`=0 next cycle, `busy`=0.
- `req`=4'b1111 held, `done` pulsed each grant → grant order 0,1,2,3,0 with one zero-`grant` cycle between each.
- HOLD_MAX=3, `req`=4'b0100 held, no `done` → `grant`=0100 for exactly 3 cycles, `timeout`=1 one cycle, re-granted to input 2 after dead cycle.
- Owner 1 drops `req[1]` mid-grant while `req`=4'b1001 → RELEASE, then grant input 3 (rotation from 1), `timeout`=0.
- `rst` asserted during GRANT of input 2 → next cycle `grant`=0, `sel`=0, `busy`=0, `timeout`=0; next `req`=4'b1111 grants input 0.
- `done` and counter==HOLD_MAX same cycle → release with `timeout`=0.

Source files
------------

// File: rtl/mux4_pkg.sv
// Shared constants for the 4:1 mux select arbiter: FSM state codes and widths,
// plus the modular index helper used by the rotating-priority picker.
package mux4_pkg;

  localparam int SEL_W = 2;
  localparam int N_IN  = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // Index arithmetic wraps naturally at SEL_W bits, giving mod-N_IN rotation.
  function automatic logic [SEL_W-1:0] rot_idx(input logic [SEL_W-1:0] base,
                                               input logic [SEL_W-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick: searches last+1, last+2, ... (mod 4)
// and reports the first requesting index.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand_idx [N_IN];
  logic [N_IN-1:0]  cand_hit;

  // Candidate gi is the (gi+1)-th position after the pointer; the pointer itself comes last.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_cand
    assign cand_idx[gi] = rot_idx(last, SEL_W'(gi + 1));
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/mux4_sel_arb.sv
// Round-robin select sequencer for a 4:1 mux: grants one requester at a time,
// bounds each grant by HOLD_MAX cycles and inserts one dead cycle between owners.
module mux4_sel_arb
  import mux4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  grant,
  output logic             busy,
  output logic             timeout
);

  localparam int               CNT_W   = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_IN-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             exit_grant;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req  = req[sel_q];
  assign exit_grant = done || !owner_req || (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_found) begin
          state_d = GRANT;
          grant_d = N_IN'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (exit_grant) begin
          state_d   = RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          last_d    = sel_q;
          // Only a pure budget expiry counts as a timeout.
          timeout_d = !done && owner_req;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= SEL_W'(N_IN - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_sel_arb.sv
// Bench for mux4_sel_arb: three instances (HOLD_MAX 8, 3, 1) share stimulus and are
// checked every cycle against an owner/pointer model, plus literal spot checks.
module tb_mux4_sel_arb;

  localparam int N_DUT = 3;

  function automatic int hm_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 3 : 1);
  endfunction

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic [1:0] sel_w   [N_DUT];
  logic [3:0] grant_w [N_DUT];
  logic       busy_w  [N_DUT];
  logic       to_w    [N_DUT];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    mux4_sel_arb #(.HOLD_MAX((gi == 0) ? 8 : ((gi == 1) ? 3 : 1))) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .sel     (sel_w[gi]),
      .grant   (grant_w[gi]),
      .busy    (busy_w[gi]),
      .timeout (to_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc%0d: got %0h want %0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Model: either someone owns the mux (owner>=0) or nobody does. A grant ends
  // by done, request drop or budget; a new owner is only chosen while nobody owns.
  int m_owner [N_DUT] = '{-1, -1, -1};
  int m_last  [N_DUT] = '{3, 3, 3};
  int m_held  [N_DUT] = '{0, 0, 0};
  int m_sel   [N_DUT] = '{0, 0, 0};
  bit m_to    [N_DUT] = '{0, 0, 0};

  task automatic model_step(input int i);
    int w;
    if (rst) begin
      m_owner[i] = -1; m_last[i] = 3; m_held[i] = 0; m_sel[i] = 0; m_to[i] = 0;
    end else if (m_owner[i] >= 0) begin
      if (done || !req[m_owner[i]] || m_held[i] >= hm_of(i)) begin
        m_to[i]    = !done && req[m_owner[i]];
        m_last[i]  = m_owner[i];
        m_owner[i] = -1;
      end else begin
        m_to[i]   = 0;
        m_held[i] = m_held[i] + 1;
      end
    end else begin
      m_to[i] = 0;
      for (int k = 1; k <= 4; k++) begin
        w = (m_last[i] + k) % 4;
        if (req[w] && m_owner[i] < 0) begin
          m_owner[i] = w; m_sel[i] = w; m_held[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] eg;
    for (int i = 0; i < N_DUT; i++) model_step(i);
    #1;
    cyc++;
    for (int i = 0; i < N_DUT; i++) begin
      eg = '0;
      if (m_owner[i] >= 0) eg[m_owner[i]] = 1'b1;
      chk("grant", i, grant_w[i], eg);
      chk("sel", i, sel_w[i], m_sel[i]);
      chk("busy", i, busy_w[i], (m_owner[i] >= 0));
      chk("timeout", i, to_w[i], m_to[i]);
      $display("cyc%0d inst%0d req=%b done=%b rst=%b grant=%b sel=%0d busy=%b to=%b",
               cyc, i, req, done, rst, grant_w[i], sel_w[i], busy_w[i], to_w[i]);
    end
  end

  task automatic drive(input logic [3:0] r, input logic d, input logic s);
    req = r; done = d; rst = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; req = '0; done = 1'b0;

    // Reset state and a single grant/done handshake
    do_reset();
    chk("rst_grant", 0, grant_w[0], 4'b0000);
    chk("rst_sel", 0, sel_w[0], 2'd0);
    chk("rst_busy", 0, busy_w[0], 1'b0);
    chk("rst_to", 0, to_w[0], 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    chk("t1_grant", 0, grant_w[0], 4'b0001);
    chk("t1_sel", 0, sel_w[0], 2'd0);
    chk("t1_busy", 0, busy_w[0], 1'b1);
    drive(4'b0001, 1'b1, 1'b0);
    chk("t1_rel_grant", 0, grant_w[0], 4'b0000);
    chk("t1_rel_busy", 0, busy_w[0], 1'b0);
    drive(4'b0000, 1'b0, 1'b0);

    // Round robin with all requests and a done per grant
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b0, 1'b0);
      e = 4'b0001 << (k % 4);
      chk("rr_order", 0, grant_w[0], e);
      drive(4'b1111, 1'b1, 1'b0);
      chk("rr_dead", 0, grant_w[0], 4'b0000);
    end

    // Budget expiry: HOLD_MAX=3 and HOLD_MAX=1 instances
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0100, 1'b0, 1'b0);
      chk("hm3_grant", 1, grant_w[1], (k == 3) ? 4'b0000 : 4'b0100);
      chk("hm3_to", 1, to_w[1], (k == 3));
      chk("hm3_sel", 1, sel_w[1], 2'd2);
      chk("hm1_grant", 2, grant_w[2], (k % 2 == 0) ? 4'b0100 : 4'b0000);
      chk("hm1_to", 2, to_w[2], (k % 2 == 1));
    end

    // Owner drops its request; rotation continues from the dropped owner
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    chk("drop_own", 0, grant_w[0], 4'b0010);
    drive(4'b1001, 1'b0, 1'b0);
    chk("drop_rel", 0, grant_w[0], 4'b0000);
    chk("drop_to", 0, to_w[0], 1'b0);
    drive(4'b1001, 1'b0, 1'b0);
    chk("drop_next", 0, grant_w[0], 4'b1000);
    chk("drop_sel", 0, sel_w[0], 2'd3);

    // Reset in the middle of a grant
    do_reset();
    drive(4'b0100, 1'b0, 1'b0);
    chk("mid_own", 0, grant_w[0], 4'b0100);
    drive(4'b0100, 1'b0, 1'b1);
    chk("mid_grant", 0, grant_w[0], 4'b0000);
    chk("mid_sel", 0, sel_w[0], 2'd0);
    chk("mid_to_hm1", 2, to_w[2], 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    chk("mid_regrant", 0, grant_w[0], 4'b0001);

    // done coincides with budget expiry on HOLD_MAX=3
    do_reset();
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    chk("both_held", 1, grant_w[1], 4'b0001);
    drive(4'b0001, 1'b1, 1'b0);
    chk("both_grant", 1, grant_w[1], 4'b0000);
    chk("both_to", 1, to_w[1], 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
